// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared grid types, round states and popcount for the trace round checker
package trace_pkg;

  localparam int GRID_DIM   = 4;
  localparam int GRID_CELLS = GRID_DIM * GRID_DIM;

  typedef logic [GRID_CELLS-1:0] trace_t;

  typedef enum logic [2:0] {
    IDLE,
    SHOW,
    INPUT,
    JUDGE,
    RESULT
  } state_e;

  function automatic logic [4:0] popcount(input trace_t t);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < GRID_CELLS; i++) begin
      cnt = cnt + {4'b0000, t[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/trace_compare.sv
// rtl/trace_compare.sv - number of cells that differ between two grids
module trace_compare
  import trace_pkg::*;
(
  input  trace_t     a_i,
  input  trace_t     b_i,
  output logic [4:0] mismatch_count_o
);

  assign mismatch_count_o = popcount(a_i ^ b_i);

endmodule

// File: rtl/trace_round_checker.sv
// rtl/trace_round_checker.sv - captures a trace, shows it, collects the player grid and scores the round
module trace_round_checker
  import trace_pkg::*;
#(
  parameter int SHOW_CYCLES    = 50_000_000,
  parameter int TIMEOUT_CYCLES = 250_000_000,
  parameter int TIMER_W        = 28
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] trace,
  input  logic        save_trace,
  output logic        trace_saved,
  input  logic [3:0]  cell_idx,
  input  logic        cell_toggle,
  input  logic        submit,
  input  logic        next_round,
  output logic [15:0] show_trace,
  output logic [15:0] player_grid,
  output logic        result_valid,
  output logic        match,
  output logic [4:0]  mismatch_count,
  output logic        timed_out,
  output logic        busy
);

  localparam logic [TIMER_W-1:0] SHOW_LAST    = TIMER_W'(SHOW_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  trace_t             trace_q, trace_d;
  trace_t             grid_q, grid_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               saved_q, saved_d;
  logic [4:0]         mm_q, mm_d;
  logic               match_q, match_d;
  logic               to_q, to_d;
  logic [4:0]         cmp_count;

  trace_compare u_compare (
    .a_i              (grid_q),
    .b_i              (trace_q),
    .mismatch_count_o (cmp_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      trace_q <= '0;
      grid_q  <= '0;
      timer_q <= '0;
      saved_q <= 1'b0;
      mm_q    <= '0;
      match_q <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      trace_q <= trace_d;
      grid_q  <= grid_d;
      timer_q <= timer_d;
      saved_q <= saved_d;
      mm_q    <= mm_d;
      match_q <= match_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    trace_d = trace_q;
    grid_d  = grid_q;
    timer_d = timer_q;
    saved_d = 1'b0;
    mm_d    = mm_q;
    match_d = match_q;
    to_d    = to_q;
    case (state_q)
      IDLE: begin
        if (save_trace) begin
          trace_d = trace;
          grid_d  = '0;
          timer_d = '0;
          saved_d = 1'b1;
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (timer_q == SHOW_LAST) begin
          timer_d = '0;
          state_d = INPUT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      INPUT: begin
        if (cell_toggle) begin
          grid_d[cell_idx] = ~grid_q[cell_idx];
        end
        // Submit outranks a timeout landing in the same cycle.
        if (submit) begin
          to_d    = 1'b0;
          timer_d = '0;
          state_d = JUDGE;
        end else if (timer_q == TIMEOUT_LAST) begin
          to_d    = 1'b1;
          timer_d = '0;
          state_d = JUDGE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      JUDGE: begin
        mm_d    = cmp_count;
        match_d = (cmp_count == 5'd0) && !to_q;
        timer_d = '0;
        state_d = RESULT;
      end
      RESULT: begin
        if (next_round) begin
          mm_d    = '0;
          match_d = 1'b0;
          to_d    = 1'b0;
          timer_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign trace_saved    = saved_q;
  assign show_trace     = (state_q == SHOW) ? trace_q : '0;
  assign player_grid    = grid_q;
  assign result_valid   = (state_q == RESULT);
  assign match          = match_q;
  assign mismatch_count = mm_q;
  assign timed_out      = to_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_trace_round_checker.sv
// tb/tb_trace_round_checker.sv - directed table, reset/protocol sequences and randomized rounds against a reference model
module tb_trace_round_checker;

  localparam int SHOW    = 4;
  localparam int TIMEOUT = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] trace;
  logic        save_trace;
  logic        trace_saved;
  logic [3:0]  cell_idx;
  logic        cell_toggle;
  logic        submit;
  logic        next_round;
  logic [15:0] show_trace;
  logic [15:0] player_grid;
  logic        result_valid;
  logic        match;
  logic [4:0]  mismatch_count;
  logic        timed_out;
  logic        busy;

  int n_total = 0;
  int n_pass  = 0;

  trace_round_checker #(
    .SHOW_CYCLES    (SHOW),
    .TIMEOUT_CYCLES (TIMEOUT),
    .TIMER_W        (28)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .trace          (trace),
    .save_trace     (save_trace),
    .trace_saved    (trace_saved),
    .cell_idx       (cell_idx),
    .cell_toggle    (cell_toggle),
    .submit         (submit),
    .next_round     (next_round),
    .show_trace     (show_trace),
    .player_grid    (player_grid),
    .result_valid   (result_valid),
    .match          (match),
    .mismatch_count (mismatch_count),
    .timed_out      (timed_out),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] tr;
    logic [15:0] mask;
    int          sub;     // 0 = let it time out, -1 = submit with the last toggle
    int          save_e;  // INPUT cycle carrying a stray save_trace, 0 = none
    logic        em;
    logic [4:0]  emm;
    logic        eto;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [15:0] tr);
    trace      = tr;
    save_trace = 1'b1;
    tick();
    chk("trace_saved_pulse", {31'b0, trace_saved}, 1);
    chk("busy_in_show", {31'b0, busy}, 1);
    save_trace = 1'b0;
    trace      = 16'($urandom);
  endtask

  task automatic play(input logic [15:0] tr, input int ntog, input int cells[16],
                      input int sub_edge, input int save_edge, input logic [15:0] exp_grid,
                      input logic exp_match, input logic [4:0] exp_mm, input logic exp_to);
    int show_cnt;
    int rv_edge;
    int exp_edge;
    bit extra_saved;
    bit saw_saved;
    show_cnt    = 0;
    extra_saved = 0;
    while (show_trace == tr && show_cnt < 20) begin
      show_cnt++;
      tick();
      if (trace_saved) extra_saved = 1;
    end
    chk("show_len", show_cnt, SHOW);
    chk("show_off_in_input", {16'b0, show_trace}, 0);
    chk("saved_once", {31'b0, extra_saved}, 0);
    rv_edge   = 0;
    saw_saved = 0;
    for (int c = 1; c <= TIMEOUT + 4 && rv_edge == 0; c++) begin
      cell_toggle = (c <= ntog);
      cell_idx    = (c <= ntog) ? 4'(cells[c-1]) : 4'($urandom_range(0, 15));
      submit      = (c == sub_edge);
      save_trace  = (c == save_edge);
      tick();
      cell_toggle = 1'b0;
      submit      = 1'b0;
      save_trace  = 1'b0;
      if (trace_saved) saw_saved = 1;
      if (result_valid) rv_edge = c;
    end
    exp_edge = ((sub_edge >= 1) ? sub_edge : TIMEOUT) + 1;
    chk("result_latency", rv_edge, exp_edge);
    chk("no_saved_in_round", {31'b0, saw_saved}, 0);
    chk("player_grid", {16'b0, player_grid}, {16'b0, exp_grid});
    chk("match", {31'b0, match}, {31'b0, exp_match});
    chk("mismatch_count", {27'b0, mismatch_count}, {27'b0, exp_mm});
    chk("timed_out", {31'b0, timed_out}, {31'b0, exp_to});
    for (int k = 0; k < 3; k++) begin
      cell_toggle = 1'b1;
      cell_idx    = 4'($urandom_range(0, 15));
      submit      = 1'b1;
      save_trace  = 1'b1;
      tick();
      chk("result_hold",
          {7'b0, result_valid, match, mismatch_count, timed_out, player_grid, trace_saved, busy},
          {7'b0, 1'b1, exp_match, exp_mm, exp_to, exp_grid, 1'b0, 1'b1});
    end
    cell_toggle = 1'b0;
    submit      = 1'b0;
    next_round  = 1'b1;
    tick();
    save_trace  = 1'b0;
    next_round  = 1'b0;
    chk("after_next_round",
        {8'b0, result_valid, match, mismatch_count, timed_out, busy, show_trace},
        0);
    tick();
  endtask

  task automatic run_vec(input vec_t v);
    int cells[16];
    int ntog;
    int sub;
    ntog = 0;
    for (int i = 0; i < 16; i++) cells[i] = 0;
    for (int i = 0; i < 16; i++) begin
      if (v.mask[i]) begin
        cells[ntog] = i;
        ntog++;
      end
    end
    sub = (v.sub == -1) ? ntog : v.sub;
    capture(v.tr);
    play(v.tr, ntog, cells, sub, v.save_e, v.mask, v.em, v.emm, v.eto);
  endtask

  task automatic run_random();
    int          cells[16];
    int          ntog;
    int          sub;
    logic [15:0] tr;
    logic [15:0] grid;
    logic [4:0]  mm;
    logic        to;
    tr = 16'($urandom);
    if (tr == 16'h0000) tr = 16'h0100;
    ntog = $urandom_range(0, 8);
    for (int i = 0; i < 16; i++) cells[i] = $urandom_range(0, 15);
    if ($urandom_range(0, 3) == 0) sub = 0;
    else sub = $urandom_range((ntog > 0) ? ntog : 1, TIMEOUT);
    grid = '0;
    for (int i = 0; i < ntog; i++) grid = grid ^ (16'h0001 << cells[i]);
    to = (sub == 0);
    mm = 5'($countones(grid ^ tr));
    capture(tr);
    play(tr, ntog, cells, sub, 0, grid, (mm == 0) && !to, mm, to);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int empty[16];
    for (int i = 0; i < 16; i++) empty[i] = 0;

    tbl[0] = '{16'h8421, 16'h8421, 5,  0, 1'b1, 5'd0, 1'b0};
    tbl[1] = '{16'h000F, 16'h0013, 4,  0, 1'b0, 5'd3, 1'b0};
    tbl[2] = '{16'h0001, 16'h0000, 0,  0, 1'b0, 5'd1, 1'b1};
    tbl[3] = '{16'h0001, 16'h0001, -1, 0, 1'b1, 5'd0, 1'b0};
    tbl[4] = '{16'h00F0, 16'h00F0, 10, 0, 1'b1, 5'd0, 1'b0};
    tbl[5] = '{16'hA5A5, 16'h0000, 3,  2, 1'b0, 5'd8, 1'b0};
    tbl[6] = '{16'h0003, 16'h0003, 0,  0, 1'b0, 5'd0, 1'b1};

    reset       = 1'b1;
    trace       = '0;
    save_trace  = 1'b0;
    cell_idx    = '0;
    cell_toggle = 1'b0;
    submit      = 1'b0;
    next_round  = 1'b0;
    repeat (3) tick();
    chk("reset_state",
        {8'b0, trace_saved, show_trace, result_valid, match, mismatch_count, timed_out, busy},
        0);
    chk("reset_grid", {16'b0, player_grid}, 0);
    reset = 1'b0;
    next_round = 1'b1;
    tick();
    next_round = 1'b0;
    chk("next_round_in_idle", {31'b0, busy}, 0);

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // Reset landing in SHOW while the generator still holds save_trace.
    trace      = 16'h3C3C;
    save_trace = 1'b1;
    tick();
    chk("pre_reset_saved", {31'b0, trace_saved}, 1);
    tick();
    reset = 1'b1;
    tick();
    chk("reset_in_show",
        {8'b0, trace_saved, show_trace, result_valid, match, mismatch_count, timed_out, busy},
        0);
    chk("reset_in_show_grid", {16'b0, player_grid}, 0);
    trace = 16'h0FF0;
    reset = 1'b0;
    tick();
    chk("post_reset_saved", {31'b0, trace_saved}, 1);
    save_trace = 1'b0;
    play(16'h0FF0, 0, empty, 1, 0, 16'h0000, 1'b0, 5'd8, 1'b0);

    for (int r = 0; r < 20; r++) run_random();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/trace_round_checker.md
Name: trace_round_checker

Overview:
- Consumer end of the random trace handshake: accepts a 16-bit 4x4 trace from the trace generator (save_trace / trace_saved), stores it, shows it for a fixed window, then collects the player's drawn grid.
- On submit or timeout, compares the player grid with the stored trace and reports match and mismatch count.
- Sits between the trace generator and the game/display logic. One round per handshake.

Parameters:
- SHOW_CYCLES, 50_000_000, cycles the stored trace is presented on show_trace.
- TIMEOUT_CYCLES, 250_000_000, cycles allowed in INPUT before forced judgement.
- TIMER_W, 28, counter width; must hold max(SHOW_CYCLES, TIMEOUT_CYCLES)-1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- trace  in  16  generator trace; bit k = row k/4, column k%4.
- save_trace  in  1  generator: trace valid, level held until trace_saved.
- trace_saved  out  1  one-cycle pulse: trace captured.
- cell_idx  in  4  player cell index.
- cell_toggle  in  1  toggle player_grid[cell_idx], one per cycle.
- submit  in  1  player finished.
- next_round  in  1  leave RESULT, return to IDLE.
- show_trace  out  16  stored trace during SHOW, else 0.
- player_grid  out  16  current player grid.
- result_valid  out  1  high throughout RESULT.
- match  out  1  player_grid == stored trace and not timed out; valid with result_valid.
- mismatch_count  out  5  popcount(player_grid XOR stored trace), range 0..16.
- timed_out  out  1  round ended by timeout; valid with result_valid.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, SHOW, INPUT, JUDGE, RESULT.
- Reset is synchronous and applies in any state. It forces IDLE and zeroes all outputs, stored trace, player_grid and the timer. If save_trace is still high after reset, capture occurs normally from IDLE.
- IDLE: if save_trace=1 at edge N, the trace is latched at that edge. At N+1: trace_saved=1 for exactly one cycle, state=SHOW, timer=0, player_grid cleared.
- save_trace in any non-IDLE state is ignored and produces no trace_saved.
- SHOW: show_trace = stored trace. The timer increments each cycle. After SHOW_CYCLES cycles, go to INPUT with timer=0 and show_trace=0. cell_toggle and submit are ignored.
- INPUT:
  - cell_toggle flips player_grid[cell_idx] at the next edge.
  - submit moves to JUDGE.
  - A toggle and submit in the same cycle both take effect; the toggle is included in the judgement.
  - The timer increments each cycle. On the cycle where timer == TIMEOUT_CYCLES-1 with no submit, go to JUDGE with timed_out=1.
  - Submit and timeout in the same cycle: submit wins and timed_out=0.
- JUDGE: one cycle. Register mismatch_count = popcount(grid XOR trace) and match = (mismatch_count==0) & ~timed_out. Go to RESULT.
- Latency: submit sampled at edge M gives JUDGE at M+1 and result_valid=1 at M+2.
- RESULT:
  - result_valid, match, mismatch_count and timed_out are held stable.
  - player_grid is frozen; inputs other than next_round are ignored.
  - next_round goes to IDLE, clearing result_valid, match, mismatch_count and timed_out. The stored trace is retained but invisible.
- next_round outside RESULT is ignored.
- Timer does not wrap; it is cleared on every state entry.

Decomposition:
- Package trace_pkg holds:
  - GRID_DIM=4 and GRID_CELLS=16.
  - The state enum {IDLE, SHOW, INPUT, JUDGE, RESULT}.
  - The trace_t 16-bit typedef.
- The popcount function is shared with future scoring logic and goes in trace_pkg.
- One natural sub-module, trace_compare: a combinational XOR plus popcount of two trace_t values, producing mismatch_count. Its output is registered in the parent during JUDGE.

Test Plan (SHOW_CYCLES=4, TIMEOUT_CYCLES=10):
- Capture: trace=16'h8421 with save_trace held high from IDLE -> trace_saved pulses once, one cycle later. show_trace=16'h8421 for exactly 4 cycles, then 0; busy=1.
- Exact match: toggle cells 0, 5, 10, 15, then submit -> result_valid two cycles after submit; match=1, mismatch_count=0, timed_out=0.
- Partial: trace=16'h000F; toggle cells 0, 1, 4; submit -> match=0, mismatch_count=3. Then next_round -> IDLE, result_valid=0.
- Timeout: trace=16'h0001, no submit -> JUDGE after 10 INPUT cycles; timed_out=1, match=0, mismatch_count=1.
- Collisions:
  - Toggle cell 0 and submit in the same cycle with trace=16'h0001 -> match=1.
  - Submit on the final timeout cycle -> timed_out=0.
- Protocol/reset:
  - save_trace pulsed during INPUT -> no trace_saved and state unchanged.
  - Reset asserted in SHOW with save_trace still high -> all outputs 0 the next cycle, then a fresh capture and trace_saved pulse.
